// File: rtl/cp0_except_pkg.sv
// Shared CP0 constants: bus width, register numbers and exception codes.
// The pipeline controller decodes the same exception-code constants.
package cp0_except_pkg;

    localparam int unsigned REG_BUS_W = 32;
    localparam int unsigned EXC_W     = 4;
    localparam int unsigned REG_ADR_W = 5;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [REG_ADR_W-1:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [REG_ADR_W-1:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [REG_ADR_W-1:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [REG_ADR_W-1:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [REG_ADR_W-1:0] CP0_REG_EPC     = 5'd14;

    localparam logic [EXC_W-1:0] EXC_NONE = 4'h0;
    localparam logic [EXC_W-1:0] EXC_INT  = 4'h1;
    localparam logic [EXC_W-1:0] EXC_RI   = 4'ha;
    localparam logic [EXC_W-1:0] EXC_OV   = 4'hc;
    localparam logic [EXC_W-1:0] EXC_TRAP = 4'hd;
    localparam logic [EXC_W-1:0] EXC_ERET = 4'he;

    // Codes that enter exception level and record ExcCode.
    function automatic logic is_fault(input logic [EXC_W-1:0] code);
        return (code != EXC_NONE) && (code != EXC_ERET);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer; only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_except_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          count_o,
    output logic [31:0]          compare_o,
    output logic                 timer_int_o
);

    logic wr_count;
    logic wr_compare;

    assign wr_count   = we_i && (waddr_i == CP0_REG_COUNT);
    assign wr_compare = we_i && (waddr_i == CP0_REG_COMPARE);

    // Match raises the interrupt; only a Compare write drops it again.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o     <= ZERO_WORD;
            compare_o   <= ZERO_WORD;
            timer_int_o <= 1'b0;
        end else begin
            count_o <= wr_count ? wdata_i : count_o + 32'd1;
            if (wr_compare) begin
                compare_o   <= wdata_i;
                timer_int_o <= 1'b0;
            end else if ((compare_o != ZERO_WORD) && (count_o == compare_o)) begin
                timer_int_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_except.sv
// CP0 register file (Status/Cause/EPC) plus exception arbiter.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_except
    import cp0_except_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic        exc_valid_i,
    input  logic        stall_i,
    input  logic        exc_ri_i,
    input  logic        exc_ov_i,
    input  logic        exc_trap_i,
    input  logic        exc_eret_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    output logic [3:0]  execode_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic [7:0]  cause_ip;
    logic        int_req;
    logic [31:0] status_word;
    logic [31:0] cause_word;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .count_o     (count),
        .compare_o   (compare),
        .timer_int_o (timer_int_o)
    );
`else
    assign count       = ZERO_WORD;
    assign compare     = ZERO_WORD;
    assign timer_int_o = 1'b0;
`endif

    assign cause_ip    = {ip_hw[5] | timer_int_o, ip_hw[4:0], ip_sw};
    assign int_req     = status_ie && !status_exl && ((cause_ip & status_im) != 8'h00);
    assign status_word = {16'h0000, status_im, 6'h00, status_exl, status_ie};
    assign cause_word  = {cause_bd, 15'h0000, cause_ip, 1'b0, exc_code, 2'b00};
    assign epc_o       = (we_i && (waddr_i == CP0_REG_EPC)) ? wdata_i : epc;

    // Priority arbiter, gated by the take condition.
    always_comb begin
        execode_o = EXC_NONE;
        if (!rst && exc_valid_i && !stall_i) begin
            if (int_req)         execode_o = EXC_INT;
            else if (exc_ri_i)   execode_o = EXC_RI;
            else if (exc_ov_i)   execode_o = EXC_OV;
            else if (exc_trap_i) execode_o = EXC_TRAP;
            else if (exc_eret_i) execode_o = EXC_ERET;
        end
    end

    always_comb begin
        rdata_o = ZERO_WORD;
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else begin
            case (raddr_i)
                CP0_REG_COUNT:   rdata_o = count;
                CP0_REG_COMPARE: rdata_o = compare;
                CP0_REG_STATUS:  rdata_o = status_word;
                CP0_REG_CAUSE:   rdata_o = cause_word;
                CP0_REG_EPC:     rdata_o = epc;
                default:         rdata_o = ZERO_WORD;
            endcase
        end
    end

    // mtc0 first; exception updates then override the fields they own.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_im  <= 8'h00;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
            cause_bd   <= 1'b0;
            ip_hw      <= 6'h00;
            ip_sw      <= 2'b00;
            exc_code   <= 5'h00;
            epc        <= ZERO_WORD;
        end else begin
            ip_hw <= int_i;
            if (we_i) begin
                case (waddr_i)
                    CP0_REG_STATUS: begin
                        status_im  <= wdata_i[15:8];
                        status_exl <= wdata_i[1];
                        status_ie  <= wdata_i[0];
                    end
                    CP0_REG_CAUSE: ip_sw <= wdata_i[9:8];
                    CP0_REG_EPC:   epc   <= wdata_i;
                    default: ;
                endcase
            end
            if (execode_o == EXC_ERET) begin
                status_exl <= 1'b0;
            end else if (is_fault(execode_o)) begin
                status_exl <= 1'b1;
                exc_code   <= {1'b0, execode_o};
                if (!status_exl) begin
                    cause_bd <= in_delay_slot_i;
                    epc      <= in_delay_slot_i ? pc_i - 32'd4 : pc_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_except.sv
// Bench for cp0_except: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_cp0_except;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        exc_valid_i;
    logic        stall_i;
    logic        exc_ri_i;
    logic        exc_ov_i;
    logic        exc_trap_i;
    logic        exc_eret_i;
    logic [31:0] pc_i;
    logic        in_delay_slot_i;
    logic [3:0]  execode_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_except dut (
        .clk             (clk),
        .rst             (rst),
        .int_i           (int_i),
        .we_i            (we_i),
        .waddr_i         (waddr_i),
        .wdata_i         (wdata_i),
        .raddr_i         (raddr_i),
        .rdata_o         (rdata_o),
        .exc_valid_i     (exc_valid_i),
        .stall_i         (stall_i),
        .exc_ri_i        (exc_ri_i),
        .exc_ov_i        (exc_ov_i),
        .exc_trap_i      (exc_trap_i),
        .exc_eret_i      (exc_eret_i),
        .pc_i            (pc_i),
        .in_delay_slot_i (in_delay_slot_i),
        .execode_o       (execode_o),
        .epc_o           (epc_o),
        .timer_int_o     (timer_int_o)
    );

    int checks = 0;
    int errors = 0;

    // Architectural state as software sees it.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_tint;
    logic [5:0]  m_int;
    logic [1:0]  m_sw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_count, m_compare;
    bit          m_live = 0;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_pending();
        return {m_int[5] | m_tint, m_int[4:0], m_sw};
    endfunction

    function automatic logic [3:0] exp_code();
        if (rst || !exc_valid_i || stall_i) return 4'h0;
        if (m_ie && !m_exl && ((m_pending() & m_im) != 0)) return 4'h1;
        if (exc_ri_i)   return 4'ha;
        if (exc_ov_i)   return 4'hc;
        if (exc_trap_i) return 4'hd;
        if (exc_eret_i) return 4'he;
        return 4'h0;
    endfunction

    function automatic logic [31:0] reg_value(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_pending()) << 8) | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (we_i && waddr_i == raddr_i) return wdata_i;
        return reg_value(raddr_i);
    endfunction

    function automatic logic [31:0] exp_epc();
        return (we_i && waddr_i == 5'd14) ? wdata_i : m_epc;
    endfunction

    // Advance the model by one clock edge using the inputs of the ending cycle.
    task automatic model_edge();
        logic [3:0]  code;
        logic        old_exl;
        logic [31:0] old_count, old_cmp;
        if (rst) begin
            m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_tint = 0; m_int = 0; m_sw = 0;
            m_exc = 0; m_epc = 0; m_count = 0; m_compare = 0; m_live = 1;
        end else if (m_live) begin
            code = exp_code();
            old_exl = m_exl; old_count = m_count; old_cmp = m_compare;
            m_int = int_i;
            if (we_i && waddr_i == 5'd12) begin
                m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0];
            end
            if (we_i && waddr_i == 5'd13) m_sw = wdata_i[9:8];
            if (we_i && waddr_i == 5'd14) m_epc = wdata_i;
            if (TIMER) begin
                m_count = (we_i && waddr_i == 5'd9) ? wdata_i : old_count + 1;
                if (we_i && waddr_i == 5'd11) begin
                    m_compare = wdata_i;
                    m_tint = 0;
                end else if (old_cmp != 0 && old_count == old_cmp) begin
                    m_tint = 1;
                end
            end
            if (code == 4'he) begin
                m_exl = 0;
            end else if (code != 4'h0) begin
                if (!old_exl) begin
                    m_bd = in_delay_slot_i;
                    m_epc = in_delay_slot_i ? pc_i - 4 : pc_i;
                end
                m_exl = 1;
                m_exc = {1'b0, code};
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        raddr_i = a;
        #1;
        chk(name, rdata_o, exp);
    endtask

    task automatic clr();
        we_i = 0; exc_valid_i = 0; stall_i = 0; exc_ri_i = 0; exc_ov_i = 0;
        exc_trap_i = 0; exc_eret_i = 0; in_delay_slot_i = 0;
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 5'd9;
            1: return 5'd11;
            2: return 5'd12;
            3: return 5'd13;
            4: return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("execode", 32'(execode_o), 32'(exp_code()));
            chk("epc_o", epc_o, exp_epc());
            chk("rdata", rdata_o, exp_rdata());
            chk("timer_int", 32'(timer_int_o), 32'(m_tint));
        end
    end

    initial begin
        int n;
        rst = 1; int_i = 6'h3f; raddr_i = 0; waddr_i = 0; wdata_i = 0; pc_i = 0;
        clr();
        exc_valid_i = 1; exc_ri_i = 1;
        repeat (2) step();
        chk("rst_execode", 32'(execode_o), 32'h0);
        chk("rst_timer", 32'(timer_int_o), 32'h0);
        rd(5'd12, 32'h0, "rst_status");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd9,  32'h0, "rst_count");

        rst = 0; int_i = 0; clr();
        step();
        we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0401;
        step();
        we_i = 0; int_i = 6'h01;
        step();
        exc_valid_i = 1; pc_i = 32'h8000_0100;
        #1 chk("int_code", 32'(execode_o), 32'h1);
        step();
        exc_valid_i = 0;
        rd(5'd12, 32'h0000_0403, "int_status");
        rd(5'd14, 32'h8000_0100, "int_epc");
        rd(5'd13, 32'h0000_0404, "int_cause");
        exc_valid_i = 1;
        #1 chk("int_masked", 32'(execode_o), 32'h0);

        we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1234_5678; exc_eret_i = 1;
        #1 chk("eret_code", 32'(execode_o), 32'he);
        chk("eret_epc_bypass", epc_o, 32'h1234_5678);
        step();
        clr(); int_i = 0;
        rd(5'd12, 32'h0000_0401, "eret_status");
        rd(5'd14, 32'h1234_5678, "eret_epc");
        step();

        exc_valid_i = 1; exc_ri_i = 1; exc_ov_i = 1; in_delay_slot_i = 1; pc_i = 32'h0000_0040;
        #1 chk("prio_code", 32'(execode_o), 32'ha);
        step();
        clr();
        rd(5'd14, 32'h0000_003c, "ds_epc");
        rd(5'd13, 32'h8000_0028, "ds_cause");

        exc_valid_i = 1; stall_i = 1; exc_trap_i = 1;
        #1 chk("stall_code", 32'(execode_o), 32'h0);
        step();
        rd(5'd13, 32'h8000_0028, "stall_cause");
        stall_i = 0;
        #1 chk("trap_code", 32'(execode_o), 32'hd);
        step();
        clr();
        rd(5'd13, 32'h8000_0034, "trap_cause");
        rd(5'd14, 32'h0000_003c, "trap_epc_kept");

        if (TIMER) begin
            we_i = 1; waddr_i = 5'd9; wdata_i = 0;
            step();
            waddr_i = 5'd11; wdata_i = 5;
            step();
            we_i = 0;
            n = 0;
            while (!timer_int_o && n < 20) begin
                step();
                n++;
            end
            chk("timer_rise_delay", 32'(n), 32'd5);
            rd(5'd9, 32'd6, "timer_count");
            raddr_i = 5'd13;
            #1 chk("timer_ip7", 32'(rdata_o[15]), 32'h1);
            repeat (3) step();
            chk("timer_held", 32'(timer_int_o), 32'h1);
            we_i = 1; waddr_i = 5'd11; wdata_i = 0;
            step();
            we_i = 0;
            chk("timer_cleared", 32'(timer_int_o), 32'h0);
        end else begin
            we_i = 1; waddr_i = 5'd9; wdata_i = 32'h55;
            step();
            we_i = 0;
            rd(5'd9, 32'h0, "count_absent");
            chk("timer_tied", 32'(timer_int_o), 32'h0);
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) int_i = 6'($urandom);
            we_i = ($urandom_range(0, 3) == 0);
            waddr_i = pick_addr();
            wdata_i = (waddr_i == 5'd9 || waddr_i == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
            raddr_i = pick_addr();
            exc_valid_i = 1'($urandom_range(0, 1));
            stall_i = ($urandom_range(0, 3) == 0);
            exc_ri_i = ($urandom_range(0, 7) == 0);
            exc_ov_i = ($urandom_range(0, 7) == 0);
            exc_trap_i = ($urandom_range(0, 7) == 0);
            exc_eret_i = ($urandom_range(0, 5) == 0);
            pc_i = $urandom & 32'hffff_fffc;
            in_delay_slot_i = 1'($urandom_range(0, 1));
            step();
        end

        rst = 0; clr();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
